// File: rtl/univ_shift_reg_p.sv
// ----------------------------------------------------------------------------
// univ_shift_reg_p
// Parametrised universal shift register with a shift counter and a
// word-complete pulse. It is the serialiser/deserialiser building block for
// serial links.
//
// Ports:
//   clk        system clock; all state updates on its rising edge
//   rst        synchronous, active-high reset (priority over en/mode)
//   en         clock enable; 0 holds all state and forces word_done low
//   mode[2:0]  000 HOLD, 001 SHL, 010 SHR, 011 LOAD,
//              100 ROTL, 101 ROTR, 110 ASR, 111 CLEAR
//   p_in       parallel load data
//   s_in       serial input bit (used by SHL/SHR only)
//   q_out      register contents (registered)
//   s_out_msb  q_out[WIDTH-1] (combinational)
//   s_out_lsb  q_out[0] (combinational)
//   is_zero    q_out == 0 (combinational)
//   shift_cnt  shifts since the last LOAD/CLEAR/wrap (registered)
//   word_done  one-cycle pulse when WIDTH shifts complete (registered)
//   parity     XOR reduction of q_out (combinational), present only when
//              the SHIFT_REG_PARITY_EN macro is defined
// ----------------------------------------------------------------------------
module univ_shift_reg_p #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int unsigned     CNT_W     = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] p_in,
    input  logic             s_in,
    output logic [WIDTH-1:0] q_out,
    output logic             s_out_msb,
    output logic             s_out_lsb,
    output logic             is_zero,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             word_done
`ifdef SHIFT_REG_PARITY_EN
    ,
    output logic             parity
`endif
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHL   = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_LOAD  = 3'b011,
        MODE_ROTL  = 3'b100,
        MODE_ROTR  = 3'b101,
        MODE_ASR   = 3'b110,
        MODE_CLEAR = 3'b111
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] q_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             done_nxt;
    logic             is_shift;
    logic             cnt_clr;

    // Next-state data path and counter; everything holds unless en is high.
    always_comb begin
        q_nxt    = q_out;
        cnt_nxt  = shift_cnt;
        done_nxt = 1'b0;
        is_shift = 1'b0;
        cnt_clr  = 1'b0;

        if (en) begin
            case (mode_e'(mode))
                MODE_HOLD: begin
                    q_nxt = q_out;
                end
                MODE_SHL: begin
                    q_nxt    = {q_out[WIDTH-2:0], s_in};
                    is_shift = 1'b1;
                end
                MODE_SHR: begin
                    q_nxt    = {s_in, q_out[WIDTH-1:1]};
                    is_shift = 1'b1;
                end
                MODE_LOAD: begin
                    q_nxt   = p_in;
                    cnt_clr = 1'b1;
                end
                MODE_ROTL: begin
                    q_nxt    = {q_out[WIDTH-2:0], q_out[WIDTH-1]};
                    is_shift = 1'b1;
                end
                MODE_ROTR: begin
                    q_nxt    = {q_out[0], q_out[WIDTH-1:1]};
                    is_shift = 1'b1;
                end
                MODE_ASR: begin
                    q_nxt    = {q_out[WIDTH-1], q_out[WIDTH-1:1]};
                    is_shift = 1'b1;
                end
                MODE_CLEAR: begin
                    q_nxt   = '0;
                    cnt_clr = 1'b1;
                end
                default: begin
                    q_nxt = q_out;
                end
            endcase
        end

        // The shift that completes a word wraps the count and pulses word_done.
        if (cnt_clr) begin
            cnt_nxt = '0;
        end else if (is_shift) begin
            if (shift_cnt == CNT_LAST) begin
                cnt_nxt  = '0;
                done_nxt = 1'b1;
            end else begin
                cnt_nxt = shift_cnt + CNT_W'(1);
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_out     <= RESET_VAL;
            shift_cnt <= '0;
            word_done <= 1'b0;
        end else begin
            q_out     <= q_nxt;
            shift_cnt <= cnt_nxt;
            word_done <= done_nxt;
        end
    end

    // Serial taps and status derived directly from the register.
    assign s_out_msb = q_out[WIDTH-1];
    assign s_out_lsb = q_out[0];
    assign is_zero   = (q_out == '0);

`ifdef SHIFT_REG_PARITY_EN
    assign parity = ^q_out;
`endif

endmodule

// File: tb/tb_univ_shift_reg_p.sv
module tb_univ_shift_reg_p;

    localparam logic [7:0] R8 = 8'hA5;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic       s_in;
    logic [3:0] p4;
    logic [7:0] p8;

    logic [3:0] q4;
    logic       msb4, lsb4, zero4, done4;
    logic [1:0] cnt4;
    logic [7:0] q8;
    logic       msb8, lsb8, zero8, done8;
    logic [2:0] cnt8;
`ifdef SHIFT_REG_PARITY_EN
    logic       par4, par8;
`endif

    int tests = 0;
    int fails = 0;

    // Reference state kept as plain integers.
    int unsigned m_q4, m_q8, m_c4, m_c8;
    bit          m_d4, m_d8;

    univ_shift_reg_p #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .p_in(p4), .s_in(s_in),
        .q_out(q4), .s_out_msb(msb4), .s_out_lsb(lsb4), .is_zero(zero4),
        .shift_cnt(cnt4), .word_done(done4)
`ifdef SHIFT_REG_PARITY_EN
        , .parity(par4)
`endif
    );

    univ_shift_reg_p #(.WIDTH(8), .RESET_VAL(R8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .p_in(p8), .s_in(s_in),
        .q_out(q8), .s_out_msb(msb8), .s_out_lsb(lsb8), .is_zero(zero8),
        .shift_cnt(cnt8), .word_done(done8)
`ifdef SHIFT_REG_PARITY_EN
        , .parity(par8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_shift_op(input int m);
        return (m == 1) || (m == 2) || (m == 4) || (m == 5) || (m == 6);
    endfunction

    // Register update expressed as arithmetic on an unsigned value of w bits.
    function automatic int unsigned ref_q(input int w, input int unsigned q, input int m,
                                          input bit s, input int unsigned p);
        int unsigned full = 1 << w;
        int unsigned top  = 1 << (w - 1);
        case (m)
            1:       return (q * 2 + s) % full;
            2:       return q / 2 + (s ? top : 0);
            3:       return p % full;
            4:       return (q * 2) % full + q / top;
            5:       return q / 2 + (q % 2) * top;
            6:       return q / 2 + ((q >= top) ? top : 0);
            7:       return 0;
            default: return q;
        endcase
    endfunction

    task automatic ref_cnt(input int w, input int m, inout int unsigned c, output bit d);
        d = 1'b0;
        if (m == 3 || m == 7) begin
            c = 0;
        end else if (is_shift_op(m)) begin
            if (c + 1 == w) begin
                c = 0;
                d = 1'b1;
            end else begin
                c = c + 1;
            end
        end
    endtask

    function automatic bit par_of(input int unsigned v);
        return bit'($countones(v) % 2);
    endfunction

    // Drive one cycle, advance the model, and compare every output 1ns after the edge.
    task automatic cycle(input bit r, input bit e, input int m, input bit s, input int unsigned pv);
        int unsigned p_tmp;
        @(negedge clk);
        p_tmp = pv;
        rst   = r;
        en    = e;
        mode  = 3'(m);
        s_in  = s;
        p4    = p_tmp[3:0];
        p8    = p_tmp[7:0];
        @(posedge clk);
        if (r) begin
            m_q4 = 0;
            m_q8 = R8;
            m_c4 = 0;
            m_c8 = 0;
            m_d4 = 1'b0;
            m_d8 = 1'b0;
        end else if (!e) begin
            m_d4 = 1'b0;
            m_d8 = 1'b0;
        end else begin
            m_q4 = ref_q(4, m_q4, m, s, p_tmp);
            m_q8 = ref_q(8, m_q8, m, s, p_tmp);
            ref_cnt(4, m, m_c4, m_d4);
            ref_cnt(8, m, m_c8, m_d8);
        end
        #1;
        check("q4", 32'(q4), m_q4);
        check("cnt4", 32'(cnt4), m_c4);
        check("done4", 32'(done4), 32'(m_d4));
        check("zero4", 32'(zero4), 32'(m_q4 == 0));
        check("msb4", 32'(msb4), m_q4 / 8);
        check("lsb4", 32'(lsb4), m_q4 % 2);
        check("q8", 32'(q8), m_q8);
        check("cnt8", 32'(cnt8), m_c8);
        check("done8", 32'(done8), 32'(m_d8));
        check("zero8", 32'(zero8), 32'(m_q8 == 0));
        check("msb8", 32'(msb8), m_q8 / 128);
        check("lsb8", 32'(lsb8), m_q8 % 2);
`ifdef SHIFT_REG_PARITY_EN
        check("par4", 32'(par4), 32'(par_of(m_q4)));
        check("par8", 32'(par8), 32'(par_of(m_q8)));
`endif
    endtask

    initial begin
        int r;
        int m;
        rst  = 1'b1;
        en   = 1'b1;
        mode = 3'b011;
        s_in = 1'b0;
        p4   = 4'hF;
        p8   = 8'hFF;
        m_q4 = 0; m_q8 = 0; m_c4 = 0; m_c8 = 0; m_d4 = 0; m_d8 = 0;

        // Reset for two cycles while a LOAD is requested.
        cycle(1, 1, 3, 0, 'hFF);
        cycle(1, 1, 3, 0, 'hFF);
        check("rst_q4", 32'(q4), 0);
        check("rst_q8", 32'(q8), 32'(R8));

        // Legacy sequence: LOAD 0001, SHL 1 x2, SHR 1, SHR 0 x4.
        cycle(0, 1, 3, 0, 'h01);
        cycle(0, 1, 1, 1, 0);
        check("leg_shl", 32'(q4), 4'b0011);
        cycle(0, 1, 1, 1, 0);
        cycle(0, 1, 2, 1, 0);
        check("leg_shr1", 32'(q4), 4'b1011);
        cycle(0, 1, 2, 0, 0);
        check("leg_done", 32'(done4), 1);
        cycle(0, 1, 2, 0, 0);
        cycle(0, 1, 2, 0, 0);
        cycle(0, 1, 2, 0, 0);
        check("leg_zero", 32'(zero4), 1);

        // Rotate: LOAD 1001, ROTL, ROTR, ROTR.
        cycle(0, 1, 3, 0, 'h09);
        cycle(0, 1, 4, 0, 0);
        check("rotl", 32'(q4), 4'b0011);
        cycle(0, 1, 5, 0, 0);
        cycle(0, 1, 5, 0, 0);
        check("rot_end", 32'(q4), 4'b1100);

        // Arithmetic shift on the 8-bit instance.
        cycle(0, 1, 3, 0, 'h90);
        cycle(0, 1, 6, 0, 0);
        cycle(0, 1, 6, 0, 0);
        check("asr_q", 32'(q8), 8'hE4);
        check("asr_cnt", 32'(cnt8), 2);

        // Enable low holds everything, then reset overrides a LOAD.
        cycle(0, 1, 3, 0, 'h06);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 0);
        check("hold_q", 32'(q4), 4'b1000);
        check("hold_cnt", 32'(cnt4), 2);
        cycle(1, 1, 3, 0, 'h0A);
        check("rst_mid", 32'(q4), 0);

        // Clear after a load.
        cycle(0, 1, 3, 0, 'h07);
        cycle(0, 1, 7, 0, 0);
        check("clr_q", 32'(q4), 0);

        // Randomised traffic, biased towards shifts so both widths wrap.
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 15));
            if (r < 12) begin
                case ($urandom_range(0, 4))
                    0: m = 1;
                    1: m = 2;
                    2: m = 4;
                    3: m = 5;
                    default: m = 6;
                endcase
            end else begin
                case ($urandom_range(0, 2))
                    0: m = 0;
                    1: m = 3;
                    default: m = 7;
                endcase
            end
            cycle(($urandom_range(0, 40) == 0), ($urandom_range(0, 4) != 0), m,
                  1'($urandom_range(0, 1)), $urandom_range(0, 255));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg_p.md
Name: univ_shift_reg_p

Overview:
- Parametrised universal shift register; successor to the 4-bit lab shift register.
- Adds generic WIDTH, rotate, arithmetic shift, clear, clock enable, synchronous reset and a shift counter with word-complete pulse.
- Serves as the serialiser/deserialiser building block for the upcoming serial-link exercises.
- Mode codes 01/10/11 keep the same meaning as the 4-bit block.

Parameters:
- WIDTH, 8, register width in bits; legal range WIDTH >= 2.
- RESET_VAL, '0, value loaded into q_out on reset (WIDTH bits).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  clock enable; when 0, all state holds.
- mode  input  3  operation select (encoding under Behaviour).
- p_in  input  WIDTH  parallel load data.
- s_in  input  1  serial input bit.
- q_out  output  WIDTH  register contents (registered).
- s_out_msb  output  1  q_out[WIDTH-1] (combinational).
- s_out_lsb  output  1  q_out[0] (combinational).
- is_zero  output  1  high when q_out == 0 (combinational from q_out).
- shift_cnt  output  max(1,$clog2(WIDTH))  shifts since the last LOAD/CLEAR/wrap (registered).
- word_done  output  1  one-cycle pulse on completion of WIDTH shifts (registered).

Behaviour:
- Reset: one clock, one reset. rst is synchronous and active-high and has priority over en and mode. On reset: q_out = RESET_VAL, shift_cnt = 0, word_done = 0; is_zero follows q_out (1 with the default RESET_VAL).
- Mode encoding. All operations apply on the rising clk edge with en = 1. Latency is 1 cycle, so the new q_out is visible after the edge.
  - 000 HOLD: q unchanged.
  - 001 SHL: q = {q[WIDTH-2:0], s_in}.
  - 010 SHR: q = {s_in, q[WIDTH-1:1]}.
  - 011 LOAD: q = p_in.
  - 100 ROTL: q = {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 ROTR: q = {q[0], q[WIDTH-1:1]}.
  - 110 ASR: q = {q[WIDTH-1], q[WIDTH-1:1]}; s_in ignored.
  - 111 CLEAR: q = 0.
- Shift counter:
  - Shift ops are SHL, SHR, ROTL, ROTR and ASR. Each increments shift_cnt when en = 1.
  - LOAD and CLEAR set shift_cnt = 0. HOLD leaves it unchanged.
  - When a shift op executes with shift_cnt == WIDTH-1: shift_cnt wraps to 0 and word_done = 1 on that same edge, visible together with the updated q_out.
  - word_done is 0 on every other edge, including all edges where en = 0.
- en = 0: q_out and shift_cnt hold; word_done is forced to 0; mode, p_in and s_in are ignored.
- Reset mid-word: an in-progress count is discarded and the LOAD/shift on that edge is ignored.
- Changing mode between consecutive cycles is legal; there is no pipeline hazard.
- No X-propagation: s_in is used only by SHL/SHR.

Optional Feature:
- Macro: SHIFT_REG_PARITY_EN.
- Defined: adds output port parity (1 bit) = XOR reduction of q_out, combinational. Parity after reset = ^RESET_VAL.
- Undefined: no parity port and no parity logic. All other behaviour is identical either way.

Test Plan:
- Reset (WIDTH=4): rst = 1 for 2 cycles with en = 1, mode = LOAD, p_in = 4'b1111 -> q_out = 0000, is_zero = 1, shift_cnt = 0, word_done = 0.
- Legacy sequence (WIDTH=4): LOAD 0001; SHL s_in=1 x2; SHR s_in=1; SHR s_in=0 x4 -> q_out = 0011, 0111, 1011, 0101, 0010, 0001, 0000.
  - word_done = 1 only on the first SHR-with-0 edge (4th shift); shift_cnt = 0 there.
  - is_zero = 1 after the final shift.
- Rotate (WIDTH=4): LOAD 1001; ROTL; ROTR; ROTR -> q_out = 0011, 1001, 1100. s_out_msb = 1 and s_out_lsb = 0 at the end.
- Arithmetic shift (WIDTH=8): LOAD 8'h90; ASR x2 with s_in = 0 -> q_out = 8'hC8, 8'hE4, shift_cnt = 2.
- Enable/reset (WIDTH=4):
  - After LOAD 0110, SHL x2: en = 0 with mode = SHL for 3 cycles -> q_out and shift_cnt = 2 unchanged, word_done = 0.
  - Then rst = 1 with en = 1, mode = LOAD, p_in = 1010 -> q_out = 0000, shift_cnt = 0.
- Clear/parity (WIDTH=4, SHIFT_REG_PARITY_EN defined): LOAD 0111 -> parity = 1; CLEAR -> q_out = 0000, parity = 0, is_zero = 1, shift_cnt = 0.
